// File: rtl/hiscore_table_if.sv
// Score-table bus: score submission handshake, result reporting and display read port.
interface hiscore_table_if #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IDXW = $clog2(DEPTH);

    logic            score_valid;
    logic [W-1:0]    score_in;
    logic            ready;
    logic            clear;
    logic            done;
    logic            placed;
    logic [IDXW-1:0] rank;
    logic            new_record;
    logic [IDXW-1:0] rd_idx;
    logic [W-1:0]    rd_score;
    logic [W-1:0]    best;

    // Game logic / display side.
    modport master (
        output score_valid, score_in, clear, rd_idx,
        input  ready, done, placed, rank, new_record, rd_score, best
    );

    // Table side.
    modport slave (
        input  score_valid, score_in, clear, rd_idx,
        output ready, done, placed, rank, new_record, rd_score, best
    );
endinterface

// File: rtl/hiscore_table.sv
// Top-N BCD high-score table, kept sorted descending, with sequential scan-and-shift insertion.
module hiscore_table #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned DEPTH  = 4
) (
    input logic           clk,
    input logic           rst,
    hiscore_table_if.slave bus
);
    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam logic [IDXW-1:0] LastIdx = IDXW'(DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StShift,
        StWrite,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    entry_q [DEPTH];
    logic [W-1:0]    entry_d [DEPTH];
    logic [W-1:0]    score_q, score_d;
    logic            score_ok_q, score_ok_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] rank_q, rank_d;
    logic            placed_q, placed_d;

    logic [IDXW-1:0] ptr_m1;
    logic            hit;

    // A score with any nibble above 9 is not BCD and must never enter the table.
    function automatic logic bcd_valid(input logic [W-1:0] s);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (s[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    assign ptr_m1 = ptr_q - IDXW'(1);
    // Strict compare: ties rank below the existing entry; zero never beats anything.
    assign hit    = score_ok_q && (score_q > entry_q[idx_q]);

    // State, table and result registers; synchronous reset aborts any insertion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            score_q    <= '0;
            score_ok_q <= 1'b0;
            idx_q      <= '0;
            ptr_q      <= '0;
            rank_q     <= '0;
            placed_q   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            score_ok_q <= score_ok_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            rank_q     <= rank_d;
            placed_q   <= placed_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    // Next-state and table update for the scan / shift / write sequence.
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        score_ok_d = score_ok_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        rank_d     = rank_q;
        placed_d   = placed_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            entry_d[i] = entry_q[i];
        end

        unique case (state_q)
            StIdle: begin
                // Clear takes priority; the simultaneous score is not accepted.
                if (bus.clear) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        entry_d[i] = '0;
                    end
                end else if (bus.score_valid) begin
                    score_d    = bus.score_in;
                    score_ok_d = bcd_valid(bus.score_in);
                    idx_d      = '0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                if (hit) begin
                    rank_d  = idx_q;
                    ptr_d   = LastIdx;
                    state_d = (idx_q == LastIdx) ? StWrite : StShift;
                end else if (idx_q == LastIdx) begin
                    placed_d = 1'b0;
                    state_d  = StDone;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            StShift: begin
                // Move entries down one slot from the bottom; the old last entry falls off.
                entry_d[ptr_q] = entry_q[ptr_m1];
                ptr_d          = ptr_m1;
                if (ptr_q == rank_q + IDXW'(1)) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                entry_d[rank_q] = score_q;
                placed_d        = 1'b1;
                state_d         = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.ready      = (state_q == StIdle);
    assign bus.done       = (state_q == StDone);
    assign bus.placed     = placed_q;
    assign bus.rank       = rank_q;
    assign bus.new_record = (state_q == StDone) && placed_q && (rank_q == '0);
    assign bus.best       = entry_q[0];
    assign bus.rd_score   = (32'(bus.rd_idx) < DEPTH) ? entry_q[bus.rd_idx] : '0;

endmodule
